// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, instruction/PC pair type and PC alignment helper for the fetch unit.
package fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } pair_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: instruction memory, redirect and decode-side signals of the fetch unit.
interface fetch_if;
    import fetch_pkg::*;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;

    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, instr_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry queue of instruction/PC pairs with synchronous flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  pair_t         din,
    output pair_t         head,
    output logic          valid,
    output logic [CW-1:0] count
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    pair_t         mem [DEPTH];
    logic [PW-1:0] rd, wr;
    logic          do_push, do_pop;

    assign valid   = count != '0;
    assign head    = mem[rd];
    assign do_pop  = pop & valid;
    // a push into a full queue is only accepted alongside a pop
    assign do_push = push & ((count != CW'(DEPTH)) | do_pop);

    always_ff @(posedge clk) begin
        if (reset | flush) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
        end else begin
            if (do_push) wr <= (wr == PW'(DEPTH - 1)) ? '0 : wr + PW'(1);
            if (do_pop) rd <= (rd == PW'(DEPTH - 1)) ? '0 : rd + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push & ~reset & ~flush) mem[wr] <= din;
    end
endmodule

// File: rtl/fetch.sv
// fetch: credit-limited instruction fetch with in-order responses, redirect flush and stale-response dropping.
module fetch
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input logic    clk,
    input logic    reset,
    fetch_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    // stale responses can pile up across back-to-back redirects, so the drop counter gets headroom
    localparam int DW = CW + 4;

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   outstanding, fifo_count;
    logic [DW-1:0]   drop;
    logic [XLEN-1:0] pcq [DEPTH];
    logic [PW-1:0]   pcq_rd, pcq_wr;
    pair_t           head;
    logic            fifo_valid, credit_ok, accept, rsp_drop, rsp_push, redirect;

    assign redirect  = bus.redirect_valid;
    assign credit_ok = int'(outstanding) + int'(fifo_count) < DEPTH;
    assign bus.imem_req_valid = ~reset & ~redirect & credit_ok;
    assign bus.imem_req_addr  = pc;
    assign accept   = bus.imem_req_valid & bus.imem_req_ready;
    assign rsp_drop = bus.imem_rsp_valid & (drop != '0);
    assign rsp_push = bus.imem_rsp_valid & (drop == '0) & (outstanding != '0);

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk  (clk),
        .reset(reset),
        .flush(redirect),
        .push (rsp_push),
        .pop  (bus.instr_ready),
        .din  ('{instr: bus.imem_rsp_data, pc: pcq[pcq_rd]}),
        .head (head),
        .valid(fifo_valid),
        .count(fifo_count)
    );

    assign bus.instr_valid = ~reset & fifo_valid;
    assign bus.instr       = bus.instr_valid ? head.instr : INSTR_NOP;
    assign bus.instr_pc    = bus.instr_valid ? head.pc : (reset ? RESET_PC : pc);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
        end else if (redirect) begin
            pc          <= align_pc(bus.redirect_pc);
            outstanding <= '0;
            drop        <= drop - DW'(rsp_drop) + DW'(outstanding) - DW'(rsp_push);
            pcq_rd      <= '0;
            pcq_wr      <= '0;
        end else begin
            if (accept) pc <= pc + XLEN'(4);
            if (accept) pcq_wr <= (pcq_wr == PW'(DEPTH - 1)) ? '0 : pcq_wr + PW'(1);
            if (rsp_push) pcq_rd <= (pcq_rd == PW'(DEPTH - 1)) ? '0 : pcq_rd + PW'(1);
            outstanding <= outstanding + CW'(accept) - CW'(rsp_push);
            drop        <= drop - DW'(rsp_drop);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) pcq[pcq_wr] <= pc;
    end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed scenarios for fetch with a cycle-stepped zero-wait memory model.
module tb_fetch;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_if b0 ();
    fetch_if b1 ();

    fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u0 (.clk(clk), .reset(reset), .bus(b0));
    fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u1 (.clk(clk), .reset(reset), .bus(b1));

    int passed = 0;
    int total = 0;
    int cyc, first_acc, first_val, acc_cnt;
    bit mem_en;
    logic [31:0] q0[$], q1[$], lpc[$], lin[$], lpc1[$];

    task automatic cycle();
        logic [31:0] a;
        if (mem_en) begin
            b0.imem_rsp_valid = q0.size() > 0;
            b0.imem_rsp_data  = 32'h0;
            if (q0.size() > 0) begin
                a = q0.pop_front();
                b0.imem_rsp_data = ~a;
            end
        end
        b1.imem_rsp_valid = q1.size() > 0;
        b1.imem_rsp_data  = 32'h0;
        if (q1.size() > 0) begin
            a = q1.pop_front();
            b1.imem_rsp_data = ~a;
        end
        #1;
        if (b0.imem_req_valid && b0.imem_req_ready) begin
            q0.push_back(b0.imem_req_addr);
            acc_cnt++;
            if (first_acc < 0) first_acc = cyc;
        end
        if (b0.instr_valid && b0.instr_ready) begin
            lpc.push_back(b0.instr_pc);
            lin.push_back(b0.instr);
            if (first_val < 0) first_val = cyc;
        end
        if (b1.imem_req_valid && b1.imem_req_ready) q1.push_back(b1.imem_req_addr);
        if (b1.instr_valid && b1.instr_ready) lpc1.push_back(b1.instr_pc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        b0.redirect_valid = 1'b0;
        b0.instr_ready = 1'b1;
        b0.imem_rsp_valid = 1'b0;
        mem_en = 1'b1;
        cycle();
        cycle();
        q0.delete(); q1.delete(); lpc.delete(); lin.delete(); lpc1.delete();
        reset = 1'b0;
        cyc = 0; first_acc = -1; first_val = -1; acc_cnt = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        b0.redirect_valid = 1'b1;
        b0.redirect_pc = 32'h40;
        cycle();
        total++; if (b0.imem_req_valid !== 1'b0) $display("FAIL rst_req_valid got=%b exp=0", b0.imem_req_valid); else passed++;
        total++; if (b0.instr_valid !== 1'b0) $display("FAIL rst_instr_valid got=%b exp=0", b0.instr_valid); else passed++;
        total++; if (b0.instr !== INSTR_NOP) $display("FAIL rst_instr got=%h exp=%h", b0.instr, INSTR_NOP); else passed++;
        total++; if (b0.instr_pc !== 32'h0) $display("FAIL rst_instr_pc got=%h exp=0", b0.instr_pc); else passed++;
        total++; if (b1.instr_pc !== 32'hFFFF_FFF8) $display("FAIL rst_instr_pc1 got=%h exp=fffffff8", b1.instr_pc); else passed++;
        total++; if (b1.imem_req_valid !== 1'b0) $display("FAIL rst_req_valid1 got=%b exp=0", b1.imem_req_valid); else passed++;
        cycle();
        b0.redirect_valid = 1'b0;
        reset = 1'b0;
        #1;
        total++; if (b0.imem_req_valid !== 1'b1) $display("FAIL rst_release_valid got=%b exp=1", b0.imem_req_valid); else passed++;
        total++; if (b0.imem_req_addr !== 32'h0) $display("FAIL rst_over_redirect got=%h exp=0", b0.imem_req_addr); else passed++;
    endtask

    task automatic test_basic();
        do_reset();
        repeat (12) cycle();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] got;
            got = lpc.size() > i ? lpc[i] : 32'hDEAD_DEAD;
            total++; if (got !== 32'(4 * i)) $display("FAIL basic_pc%0d got=%h exp=%h", i, got, 32'(4 * i)); else passed++;
        end
        total++; if (lin.size() < 1 || lin[0] !== 32'hFFFF_FFFF) $display("FAIL basic_data size=%0d exp=ffffffff", lin.size()); else passed++;
        total++; if (first_acc !== 0) $display("FAIL basic_first_acc got=%0d exp=0", first_acc); else passed++;
        total++; if (first_val - first_acc !== 2) $display("FAIL basic_latency got=%0d exp=2", first_val - first_acc); else passed++;
    endtask

    task automatic test_stall();
        bit bad;
        do_reset();
        b0.instr_ready = 1'b0;
        repeat (5) cycle();
        total++; if (acc_cnt !== 2) $display("FAIL stall_accepts got=%0d exp=2", acc_cnt); else passed++;
        total++; if (b0.imem_req_valid !== 1'b0) $display("FAIL stall_req_low got=%b exp=0", b0.imem_req_valid); else passed++;
        b0.instr_ready = 1'b1;
        cycle();
        total++; if (b0.imem_req_valid !== 1'b1) $display("FAIL stall_req_resume got=%b exp=1", b0.imem_req_valid); else passed++;
        repeat (20) cycle();
        bad = lpc.size() < 6;
        for (int i = 0; i < lpc.size(); i++)
            if (lpc[i] !== 32'(4 * i) || lin[i] !== ~lpc[i]) bad = 1'b1;
        total++; if (bad) $display("FAIL stall_sequence got_count=%0d exp=contiguous>=6", lpc.size()); else passed++;
    endtask

    task automatic test_redirect();
        do_reset();
        mem_en = 1'b0;
        b0.imem_rsp_valid = 1'b0;
        repeat (2) cycle();
        total++; if (acc_cnt !== 2) $display("FAIL redir_inflight got=%0d exp=2", acc_cnt); else passed++;
        b0.redirect_valid = 1'b1;
        b0.redirect_pc = 32'h103;
        #1;
        total++; if (b0.imem_req_valid !== 1'b0) $display("FAIL redir_req_low got=%b exp=0", b0.imem_req_valid); else passed++;
        cycle();
        b0.redirect_valid = 1'b0;
        mem_en = 1'b1;
        lpc.delete(); lin.delete();
        repeat (10) cycle();
        total++; if (lpc.size() < 1 || lpc[0] !== 32'h100) $display("FAIL redir_pc0 got=%h exp=100", lpc.size() > 0 ? lpc[0] : 32'hDEAD_DEAD); else passed++;
        total++; if (lpc.size() < 2 || lpc[1] !== 32'h104) $display("FAIL redir_pc1 got=%h exp=104", lpc.size() > 1 ? lpc[1] : 32'hDEAD_DEAD); else passed++;
        total++; if (lin.size() < 1 || lin[0] !== ~32'h100) $display("FAIL redir_data got=%h exp=%h", lin.size() > 0 ? lin[0] : 32'hDEAD_DEAD, ~32'h100); else passed++;
    endtask

    task automatic test_redirect_pop();
        bit found = 1'b0;
        bit seen = 1'b0;
        logic [31:0] stale = 32'h0;
        do_reset();
        for (int i = 0; i < 20 && !found; i++) begin
            if (b0.instr_valid && q0.size() > 0) begin
                found = 1'b1;
                stale = q0[0];
                b0.redirect_valid = 1'b1;
                b0.redirect_pc = 32'h200;
            end
            cycle();
            b0.redirect_valid = 1'b0;
        end
        total++; if (!found) $display("FAIL rpop_setup got=0 exp=1"); else passed++;
        total++; if (b0.instr_valid !== 1'b0) $display("FAIL rpop_valid_low got=%b exp=0", b0.instr_valid); else passed++;
        lpc.delete(); lin.delete();
        repeat (8) cycle();
        total++; if (lpc.size() < 1 || lpc[0] !== 32'h200) $display("FAIL rpop_target got=%h exp=200", lpc.size() > 0 ? lpc[0] : 32'hDEAD_DEAD); else passed++;
        foreach (lpc[i]) if (lpc[i] === stale) seen = 1'b1;
        total++; if (seen) $display("FAIL rpop_stale_dropped got=delivered exp=dropped pc=%h", stale); else passed++;
    endtask

    task automatic test_wrap();
        do_reset();
        repeat (12) cycle();
        total++; if (lpc1.size() < 1 || lpc1[0] !== 32'hFFFF_FFF8) $display("FAIL wrap_pc0 got=%h exp=fffffff8", lpc1.size() > 0 ? lpc1[0] : 32'hDEAD_DEAD); else passed++;
        total++; if (lpc1.size() < 2 || lpc1[1] !== 32'hFFFF_FFFC) $display("FAIL wrap_pc1 got=%h exp=fffffffc", lpc1.size() > 1 ? lpc1[1] : 32'hDEAD_DEAD); else passed++;
        total++; if (lpc1.size() < 3 || lpc1[2] !== 32'h0) $display("FAIL wrap_pc2 got=%h exp=0", lpc1.size() > 2 ? lpc1[2] : 32'hDEAD_DEAD); else passed++;
    endtask

    task automatic test_reset_late();
        do_reset();
        mem_en = 1'b0;
        b0.imem_rsp_valid = 1'b0;
        cycle();
        total++; if (acc_cnt !== 1) $display("FAIL late_inflight got=%0d exp=1", acc_cnt); else passed++;
        q0.delete();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
        b0.imem_rsp_valid = 1'b1;
        b0.imem_rsp_data = 32'hDEAD_BEEF;
        lpc.delete(); lin.delete();
        acc_cnt = 0;
        #1;
        total++; if (b0.imem_req_addr !== 32'h0) $display("FAIL late_restart_addr got=%h exp=0", b0.imem_req_addr); else passed++;
        cycle();
        b0.imem_rsp_valid = 1'b0;
        mem_en = 1'b1;
        repeat (8) cycle();
        total++; if (lin.size() < 1 || lin[0] !== 32'hFFFF_FFFF) $display("FAIL late_ignored got=%h exp=ffffffff", lin.size() > 0 ? lin[0] : 32'hDEAD_DEAD); else passed++;
        total++; if (lpc.size() < 2 || lpc[0] !== 32'h0 || lpc[1] !== 32'h4) $display("FAIL late_sequence count=%0d exp=0,4", lpc.size()); else passed++;
    endtask

    initial begin
        reset = 1'b1;
        mem_en = 1'b1;
        cyc = 0; first_acc = -1; first_val = -1; acc_cnt = 0;
        b0.imem_req_ready = 1'b1; b0.imem_rsp_valid = 1'b0; b0.imem_rsp_data = '0;
        b0.redirect_valid = 1'b0; b0.redirect_pc = '0; b0.instr_ready = 1'b1;
        b1.imem_req_ready = 1'b1; b1.imem_rsp_valid = 1'b0; b1.imem_rsp_data = '0;
        b1.redirect_valid = 1'b0; b1.redirect_pc = '0; b1.instr_ready = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_redirect_pop();
        test_wrap();
        test_reset_late();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
